// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// FSM state encoding, forwarding select codes and register index width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LU = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand bypass select: compares one EX-stage source register against the
// EX/MEM and MEM/WB destinations, newest producer first; x0 never forwards.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_i,
  input  logic [REG_IDX_W-1:0] em_rd_i,
  input  logic                 em_reg_write_i,
  input  logic [REG_IDX_W-1:0] mw_rd_i,
  input  logic                 mw_reg_write_i,
  output logic [1:0]           sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (em_reg_write_i && (em_rd_i != '0) && (em_rd_i == src_i)) begin
      sel_o = FWD_EM;
    end else if (mw_reg_write_i && (mw_rd_i != '0) && (mw_rd_i == src_i)) begin
      sel_o = FWD_MW;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [REG_IDX_W-1:0] de_rs1_i,
  input  logic [REG_IDX_W-1:0] de_rs2_i,
  input  logic [REG_IDX_W-1:0] de_rd_i,
  input  logic                 de_mem_read_i,
  input  logic                 de_reg_write_i,
  input  logic                 ex_redirect_i,
  input  logic [REG_IDX_W-1:0] em_rd_i,
  input  logic                 em_reg_write_i,
  input  logic [REG_IDX_W-1:0] mw_rd_i,
  input  logic                 mw_reg_write_i,
  output logic                 pc_stall_o,
  output logic                 fd_stall_o,
  output logic                 fd_flush_o,
  output logic                 de_flush_o,
  output logic [1:0]           fwd_a_o,
  output logic [1:0]           fwd_b_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          flush_cnt_o
`endif
);

  localparam logic [1:0] LU_INIT = (LU_BUBBLES > 1)   ? 2'(LU_BUBBLES - 2)   : 2'd0;
  localparam logic [1:0] FL_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  hz_state_t  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;
  logic       stall;
  logic       fd_flush;
  logic       de_flush;

  assign lu = de_mem_read_i && (de_rd_i != '0) &&
              ((id_uses_rs1_i && (de_rd_i == id_rs1_i)) ||
               (id_uses_rs2_i && (de_rd_i == id_rs2_i)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (ex_redirect_i) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      state_d  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_d    = FL_INIT;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            stall    = 1'b1;
            de_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d = STALL_LU;
              cnt_d   = LU_INIT;
            end
          end
        end
        STALL_LU: begin
          stall    = 1'b1;
          de_flush = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 2'd1;
        end
        FLUSH: begin
          fd_flush = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 2'd1;
        end
        default: state_d = RUN;
      endcase
    end
    // Reset cycle: controls quiet, FSM lands in RUN on the edge.
    if (rst_i) begin
      stall    = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      state_d  = RUN;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_stall_o = stall;
  assign fd_stall_o = stall;
  assign fd_flush_o = fd_flush;
  assign de_flush_o = de_flush;

  fwd_select u_fwd_a (
    .src_i          (de_rs1_i),
    .em_rd_i        (em_rd_i),
    .em_reg_write_i (em_reg_write_i),
    .mw_rd_i        (mw_rd_i),
    .mw_reg_write_i (mw_reg_write_i),
    .sel_o          (fwd_a_o)
  );

  fwd_select u_fwd_b (
    .src_i          (de_rs2_i),
    .em_rd_i        (em_rd_i),
    .em_reg_write_i (em_reg_write_i),
    .mw_rd_i        (mw_rd_i),
    .mw_reg_write_i (mw_reg_write_i),
    .sel_o          (fwd_b_o)
  );

  // de_reg_write_i is carried for interface compatibility; hazards key off loads only.
  logic unused_de_reg_write;
  assign unused_de_reg_write = de_reg_write_i;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 32'd1;
    if (fd_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controller instances with different bubble/flush
// lengths share one stimulus; each cycle's controls are compared together.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_i;
  logic [4:0] id_rs1_i, id_rs2_i;
  logic       id_uses_rs1_i, id_uses_rs2_i;
  logic [4:0] de_rs1_i, de_rs2_i, de_rd_i;
  logic       de_mem_read_i, de_reg_write_i;
  logic       ex_redirect_i;
  logic [4:0] em_rd_i, mw_rd_i;
  logic       em_reg_write_i, mw_reg_write_i;

  // {pc_stall, fd_stall, fd_flush, de_flush} per instance
  logic [3:0] ctl_a, ctl_b, ctl_c;
  logic [1:0] fwd_a_a, fwd_b_a, fwd_a_b, fwd_b_b, fwd_a_c, fwd_b_c;
`ifdef HAZARD_PERF_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b, scnt_c, fcnt_c;
`endif

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [11:0] exp;
  logic [1:0]  exp2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_BUBBLES(1), .FLUSH_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .de_rs1_i(de_rs1_i), .de_rs2_i(de_rs2_i), .de_rd_i(de_rd_i),
    .de_mem_read_i(de_mem_read_i), .de_reg_write_i(de_reg_write_i),
    .ex_redirect_i(ex_redirect_i),
    .em_rd_i(em_rd_i), .em_reg_write_i(em_reg_write_i),
    .mw_rd_i(mw_rd_i), .mw_reg_write_i(mw_reg_write_i),
    .pc_stall_o(ctl_a[3]), .fd_stall_o(ctl_a[2]),
    .fd_flush_o(ctl_a[1]), .de_flush_o(ctl_a[0]),
    .fwd_a_o(fwd_a_a), .fwd_b_o(fwd_b_a)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
`endif
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(2), .FLUSH_CYCLES(3)) dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .de_rs1_i(de_rs1_i), .de_rs2_i(de_rs2_i), .de_rd_i(de_rd_i),
    .de_mem_read_i(de_mem_read_i), .de_reg_write_i(de_reg_write_i),
    .ex_redirect_i(ex_redirect_i),
    .em_rd_i(em_rd_i), .em_reg_write_i(em_reg_write_i),
    .mw_rd_i(mw_rd_i), .mw_reg_write_i(mw_reg_write_i),
    .pc_stall_o(ctl_b[3]), .fd_stall_o(ctl_b[2]),
    .fd_flush_o(ctl_b[1]), .de_flush_o(ctl_b[0]),
    .fwd_a_o(fwd_a_b), .fwd_b_o(fwd_b_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
`endif
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(3), .FLUSH_CYCLES(1)) dut_c (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .de_rs1_i(de_rs1_i), .de_rs2_i(de_rs2_i), .de_rd_i(de_rd_i),
    .de_mem_read_i(de_mem_read_i), .de_reg_write_i(de_reg_write_i),
    .ex_redirect_i(ex_redirect_i),
    .em_rd_i(em_rd_i), .em_reg_write_i(em_reg_write_i),
    .mw_rd_i(mw_rd_i), .mw_reg_write_i(mw_reg_write_i),
    .pc_stall_o(ctl_c[3]), .fd_stall_o(ctl_c[2]),
    .fd_flush_o(ctl_c[1]), .de_flush_o(ctl_c[0]),
    .fwd_a_o(fwd_a_c), .fwd_b_o(fwd_b_c)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(scnt_c), .flush_cnt_o(fcnt_c)
`endif
  );

  task automatic clear_inputs;
    id_rs1_i = '0; id_rs2_i = '0; id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
    de_rs1_i = '0; de_rs2_i = '0; de_rd_i = '0;
    de_mem_read_i = 1'b0; de_reg_write_i = 1'b0; ex_redirect_i = 1'b0;
    em_rd_i = '0; em_reg_write_i = 1'b0; mw_rd_i = '0; mw_reg_write_i = 1'b0;
  endtask

  task automatic set_lu_rs1(input logic [4:0] rd);
    de_mem_read_i = 1'b1; de_reg_write_i = 1'b1; de_rd_i = rd;
    id_rs1_i = rd; id_uses_rs1_i = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_i = 1'b1;
    clear_inputs();
    set_lu_rs1(5'd5);
    ex_redirect_i = 1'b1;
    em_rd_i = 5'd3; em_reg_write_i = 1'b1; de_rs1_i = 5'd3;
    #1;
    exp = 12'h000;
    checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL reset_ctl got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
    exp2 = 2'b01;
    checks++;
    if (fwd_a_a !== exp2) $display("FAIL reset_fwd got=%b exp=%b", fwd_a_a, exp2);
    else passes++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_load_use;
    logic [11:0] seq [4];
    seq[0] = 12'b1101_1101_1101;
    seq[1] = 12'b0000_1101_1101;
    seq[2] = 12'b0000_0000_1101;
    seq[3] = 12'b0000_0000_0000;
    // Non-hazards first: x0 destination, unused source, non-load producer.
    @(negedge clk);
    rst_i = 1'b0; clear_inputs();
    de_mem_read_i = 1'b1; de_rd_i = 5'd0; id_rs1_i = 5'd0; id_uses_rs1_i = 1'b1;
    #1; exp = 12'h000; checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL lu_x0 got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
    @(negedge clk);
    clear_inputs(); set_lu_rs1(5'd5); id_uses_rs1_i = 1'b0;
    #1; checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL lu_unused got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
    @(negedge clk);
    clear_inputs(); set_lu_rs1(5'd5); de_mem_read_i = 1'b0;
    #1; checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL lu_noload got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i == 0) set_lu_rs1(5'd5);
      #1; checks++;
      if ({ctl_a, ctl_b, ctl_c} !== seq[i])
        $display("FAIL lu_cycle%0d got=%b exp=%b", i, {ctl_a, ctl_b, ctl_c}, seq[i]);
      else passes++;
    end
  endtask

  task automatic test_redirect;
    logic [11:0] seq [4];
    seq[0] = 12'b0011_0011_0011;
    seq[1] = 12'b0010_0010_0000;
    seq[2] = 12'b0000_0010_0000;
    seq[3] = 12'b0000_0000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      ex_redirect_i = (i == 0);
      #1; checks++;
      if ({ctl_a, ctl_b, ctl_c} !== seq[i])
        $display("FAIL redir_cycle%0d got=%b exp=%b", i, {ctl_a, ctl_b, ctl_c}, seq[i]);
      else passes++;
    end
  endtask

  task automatic test_simultaneous;
    logic [11:0] seq [6];
    seq[0] = 12'b0011_0011_0011;
    seq[1] = 12'b0011_0011_0011;
    seq[2] = 12'b0010_0010_1101;
    seq[3] = 12'b0000_0010_1101;
    seq[4] = 12'b0000_0000_1101;
    seq[5] = 12'b0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i <= 2) begin
        de_mem_read_i = 1'b1; de_rd_i = 5'd7; id_rs2_i = 5'd7; id_uses_rs2_i = 1'b1;
      end
      ex_redirect_i = (i <= 1);
      #1; checks++;
      if ({ctl_a, ctl_b, ctl_c} !== seq[i])
        $display("FAIL simul_cycle%0d got=%b exp=%b", i, {ctl_a, ctl_b, ctl_c}, seq[i]);
      else passes++;
    end
  endtask

  task automatic test_forwarding;
    @(negedge clk);
    clear_inputs();
    em_rd_i = 5'd3; mw_rd_i = 5'd3; de_rs1_i = 5'd3;
    em_reg_write_i = 1'b1; mw_reg_write_i = 1'b1;
    #1; exp2 = 2'b01; checks++;
    if (fwd_a_a !== exp2) $display("FAIL fwd_a_both got=%b exp=%b", fwd_a_a, exp2);
    else passes++;
    em_reg_write_i = 1'b0;
    #1; exp2 = 2'b10; checks++;
    if (fwd_a_a !== exp2) $display("FAIL fwd_a_mw got=%b exp=%b", fwd_a_a, exp2);
    else passes++;
    em_reg_write_i = 1'b1; em_rd_i = 5'd0; mw_rd_i = 5'd0; de_rs2_i = 5'd0;
    #1; exp2 = 2'b00; checks++;
    if (fwd_b_a !== exp2) $display("FAIL fwd_b_x0 got=%b exp=%b", fwd_b_a, exp2);
    else passes++;
    em_rd_i = 5'd9; de_rs2_i = 5'd9; mw_rd_i = 5'd9;
    #1; exp2 = 2'b01; checks++;
    if (fwd_b_a !== exp2) $display("FAIL fwd_b_em got=%b exp=%b", fwd_b_a, exp2);
    else passes++;
    em_reg_write_i = 1'b0; mw_reg_write_i = 1'b0;
    #1; exp2 = 2'b00; checks++;
    if (fwd_b_a !== exp2) $display("FAIL fwd_b_nowe got=%b exp=%b", fwd_b_a, exp2);
    else passes++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    clear_inputs(); set_lu_rs1(5'd4);
    #1; exp = 12'b1101_1101_1101; checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL rstmid_enter got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
    @(negedge clk);
    clear_inputs(); rst_i = 1'b1;
    #1; exp = 12'h000; checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL rstmid_rst got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
    @(negedge clk);
    rst_i = 1'b0;
    #1; checks++;
    if ({ctl_a, ctl_b, ctl_c} !== exp) $display("FAIL rstmid_after got=%b exp=%b", {ctl_a, ctl_b, ctl_c}, exp);
    else passes++;
`ifdef HAZARD_PERF_EN
    checks++;
    if (scnt_c !== 32'd0) $display("FAIL rstmid_scnt got=%0d exp=0", scnt_c);
    else passes++;
`endif
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_counters;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clear_inputs(); set_lu_rs1(5'd6);
      @(negedge clk); clear_inputs();
    end
    @(negedge clk); clear_inputs(); ex_redirect_i = 1'b1;
    @(negedge clk); clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (scnt_b !== 32'd8) $display("FAIL cnt_stall_b got=%0d exp=8", scnt_b);
    else passes++;
    checks++;
    if (fcnt_b !== 32'd3) $display("FAIL cnt_flush_b got=%0d exp=3", fcnt_b);
    else passes++;
    checks++;
    if (scnt_a !== 32'd4) $display("FAIL cnt_stall_a got=%0d exp=4", scnt_a);
    else passes++;
    checks++;
    if (fcnt_a !== 32'd2) $display("FAIL cnt_flush_a got=%0d exp=2", fcnt_a);
    else passes++;
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_simultaneous();
    test_forwarding();
    test_reset_mid();
`ifdef HAZARD_PERF_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
